// File: rtl/ram_sdp_be_pkg.sv
// rtl/ram_sdp_be_pkg.sv - shared types and helpers for ram_sdp_be
package ram_sdp_be_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam string RW_READ_FIRST  = "READ-FIRST";
    localparam string RW_WRITE_FIRST = "WRITE-FIRST";

    // Helpers work on a wide container; callers zero-extend inputs and cast the result back.
    localparam int MAX_W  = 1024;
    localparam int MAX_AW = $clog2(MAX_W);

    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0] old_word,
        input logic [MAX_W-1:0] new_word,
        input logic [MAX_W-1:0] be,
        input int               lane_w
    );
        logic [MAX_W-1:0] m;
        for (int j = 0; j < MAX_W; j++)
            m[j] = be[MAX_AW'(j / lane_w)] ? new_word[j] : old_word[j];
        return m;
    endfunction

    // Even parity: bit i is the XOR of lane i, so lane plus parity has an even popcount.
    function automatic logic [MAX_W-1:0] lane_parity(
        input logic [MAX_W-1:0] data,
        input int               lane_w
    );
        logic [MAX_W-1:0] p;
        p = '0;
        for (int j = 0; j < MAX_W; j++)
            p[MAX_AW'(j / lane_w)] = p[MAX_AW'(j / lane_w)] ^ data[j];
        return p;
    endfunction

endpackage

// File: rtl/ram_sdp_be_init_seq.sv
// rtl/ram_sdp_be_init_seq.sv - post-reset init sweep counter and INIT/RUN FSM
module ram_sdp_be_init_seq
    import ram_sdp_be_pkg::*;
#(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [AWIDTH-1:0] sweep_addr,
    output logic              sweep_we,
    output logic              init_done
);

    // One extra counter bit keeps the terminal count distinct from the wrap to 0.
    localparam logic [AWIDTH:0] LAST = {1'b0, {AWIDTH{1'b1}}};
    localparam logic [AWIDTH:0] ONE  = {{AWIDTH{1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [AWIDTH:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        init_done = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_we = 1'b1;
                cnt_nxt  = cnt + ONE;
                if (cnt == LAST)
                    state_nxt = ST_RUN;
            end
            ST_RUN: init_done = 1'b1;
        endcase
    end

    assign sweep_addr = cnt[AWIDTH-1:0];

endmodule

// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple-dual-port byte-enable RAM; optional lane parity via RAM_SDP_BE_PARITY_EN
module ram_sdp_be
    import ram_sdp_be_pkg::*;
#(
    parameter int                DWIDTH     = 32,
    parameter int                AWIDTH     = 8,
    parameter int                BYTE_W     = 8,
    parameter string             RW_MODE    = "READ-FIRST",
    parameter int                OUT_REG    = 0,
    parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       init_done,
    input  logic                       wr_en,
    input  logic [AWIDTH-1:0]          wr_addr,
    input  logic [DWIDTH-1:0]          wr_data,
    input  logic [DWIDTH/BYTE_W-1:0]   wr_be,
    input  logic                       rd_en,
    input  logic [AWIDTH-1:0]          rd_addr,
    output logic [DWIDTH-1:0]          rd_data,
    output logic                       rd_valid
`ifdef RAM_SDP_BE_PARITY_EN
    ,
    output logic                       parity_err
`endif
);

    localparam int NBYTES      = DWIDTH / BYTE_W;
`ifdef RAM_SDP_BE_PARITY_EN
    localparam int SW          = DWIDTH + NBYTES;
`else
    localparam int SW          = DWIDTH;
`endif
    localparam bit WRITE_FIRST = (RW_MODE == RW_WRITE_FIRST);

    logic [SW-1:0] mem [2**AWIDTH];

    logic [AWIDTH-1:0] sweep_addr;
    logic              sweep_we;

    ram_sdp_be_init_seq #(.AWIDTH(AWIDTH)) u_init_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we),
        .init_done  (init_done)
    );

    logic wr_go, rd_go;
    assign wr_go = init_done & wr_en;
    assign rd_go = init_done & rd_en;

    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_data;
    logic [NBYTES-1:0] w_be;

    always_comb begin
        w_addr = wr_addr;
        w_data = wr_data;
        w_be   = wr_be;
        if (sweep_we) begin
            w_addr = sweep_addr;
            w_data = INIT_VALUE;
            w_be   = '1;
        end
    end

`ifdef RAM_SDP_BE_PARITY_EN
    logic [NBYTES-1:0] w_par;
    assign w_par = NBYTES'(lane_parity(MAX_W'(w_data), BYTE_W));
`endif

    always_ff @(posedge clk) begin
        if (sweep_we || wr_go) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (w_be[i]) begin
                    mem[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
`ifdef RAM_SDP_BE_PARITY_EN
                    mem[w_addr][DWIDTH+i] <= w_par[i];
`endif
                end
            end
        end
    end

    logic [SW-1:0] rd_old, s1_next, s1_word, rd_word;
    logic          s1_valid;

    // Write-first collisions forward the byte merge, parity lanes merged the same way.
    always_comb begin
        rd_old  = mem[rd_addr];
        s1_next = rd_old;
        if (WRITE_FIRST && wr_go && (wr_addr == rd_addr)) begin
            s1_next[DWIDTH-1:0] = DWIDTH'(merge_bytes(MAX_W'(rd_old[DWIDTH-1:0]),
                                                      MAX_W'(w_data), MAX_W'(w_be), BYTE_W));
`ifdef RAM_SDP_BE_PARITY_EN
            s1_next[SW-1:DWIDTH] = NBYTES'(merge_bytes(MAX_W'(rd_old[SW-1:DWIDTH]),
                                                       MAX_W'(w_par), MAX_W'(w_be), 1));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go)
                s1_word <= s1_next;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [SW-1:0] s2_word;
            logic          s2_valid;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_word  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid)
                        s2_word <= s1_word;
                end
            end
            assign rd_word  = s2_word;
            assign rd_valid = s2_valid;
        end else begin : g_noreg
            assign rd_word  = s1_word;
            assign rd_valid = s1_valid;
        end
    endgenerate

    assign rd_data = rd_word[DWIDTH-1:0];

`ifdef RAM_SDP_BE_PARITY_EN
    assign parity_err = rd_valid &&
        (rd_word[SW-1:DWIDTH] != NBYTES'(lane_parity(MAX_W'(rd_data), BYTE_W)));
`endif

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - bench for ram_sdp_be: read-first/no-outreg and write-first/outreg instances
module tb_ram_sdp_be;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, wr_en, rd_en;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rf_done, wf_done, rf_valid, wf_valid;
    logic [31:0] rf_data, wf_data;
`ifdef RAM_SDP_BE_PARITY_EN
    logic        rf_perr, wf_perr;
`endif

    ram_sdp_be #(.RW_MODE("READ-FIRST"), .OUT_REG(0), .INIT_VALUE(IV)) u_rf (
        .clk(clk), .rst_n(rst_n), .init_done(rf_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rf_data), .rd_valid(rf_valid)
`ifdef RAM_SDP_BE_PARITY_EN
        , .parity_err(rf_perr)
`endif
    );

    ram_sdp_be #(.RW_MODE("WRITE-FIRST"), .OUT_REG(1), .INIT_VALUE(IV)) u_wf (
        .clk(clk), .rst_n(rst_n), .init_done(wf_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(wf_data), .rd_valid(wf_valid)
`ifdef RAM_SDP_BE_PARITY_EN
        , .parity_err(wf_perr)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        perr;
        int          due;
    } exp_t;

    exp_t q_rf[$];
    exp_t q_wf[$];

    typedef struct packed {
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [7:0]  ra;
        logic [31:0] exp_rf;
        logic [31:0] exp_wf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every rd_valid pops one expectation, checked for data and arrival cycle.
    always @(negedge clk) begin : sb
        exp_t e;
        if (rf_valid) begin
            if (q_rf.size() == 0) chk("rf_spurious_valid", 32'd1, 32'd0);
            else begin
                e = q_rf.pop_front();
                chk("rf_data", rf_data, e.data);
                chk("rf_latency", 32'(cyc), 32'(e.due));
`ifdef RAM_SDP_BE_PARITY_EN
                chk("rf_parity_err", 32'(rf_perr), 32'(e.perr));
`endif
            end
        end
        if (wf_valid) begin
            if (q_wf.size() == 0) chk("wf_spurious_valid", 32'd1, 32'd0);
            else begin
                e = q_wf.pop_front();
                chk("wf_data", wf_data, e.data);
                chk("wf_latency", 32'(cyc), 32'(e.due));
`ifdef RAM_SDP_BE_PARITY_EN
                chk("wf_parity_err", 32'(wf_perr), 32'(e.perr));
`endif
            end
        end
    end

    task automatic drive(input vec_t v, input logic perr_rf);
        @(posedge clk);
        #1;
        wr_en   = v.we;
        wr_addr = v.wa;
        wr_data = v.wd;
        wr_be   = v.be;
        rd_en   = v.re;
        rd_addr = v.ra;
        if (v.re) begin
            q_rf.push_back('{data: v.exp_rf, perr: perr_rf, due: cyc + 1});
            q_wf.push_back('{data: v.exp_wf, perr: 1'b0,    due: cyc + 2});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0);
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!rf_done && n < 1000) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk(name, 32'(n), 32'd256);
        chk({name, "_wf"}, 32'(wf_done), 32'd1);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        drive('{we: 1'b0, wa: 8'd0, wd: 32'd0, be: 4'd0, re: 1'b1, ra: a, exp_rf: exp, exp_wf: exp}, 1'b0);
    endtask

    vec_t tbl [17];

    initial begin
        tbl = '{
            '{1'b1, 8'd5,   32'h11223344, 4'hF, 1'b0, 8'd0,   32'h0,        32'h0},
            '{1'b1, 8'd5,   32'hFFFFFFFF, 4'h5, 1'b0, 8'd0,   32'h0,        32'h0},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd5,   32'h11FF33FF, 32'h11FF33FF},
            '{1'b1, 8'd9,   32'h00000007, 4'hF, 1'b0, 8'd0,   32'h0,        32'h0},
            '{1'b1, 8'd9,   32'hDEADBEEF, 4'hF, 1'b1, 8'd9,   32'h00000007, 32'hDEADBEEF},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd9,   32'hDEADBEEF, 32'hDEADBEEF},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd0,   IV,           IV},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd128, IV,           IV},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd255, IV,           IV},
            '{1'b1, 8'd10,  32'hFFFFFFFF, 4'h0, 1'b0, 8'd0,   32'h0,        32'h0},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd10,  IV,           IV},
            '{1'b1, 8'd5,   32'h12345678, 4'h3, 1'b1, 8'd5,   32'h11FF33FF, 32'h11FF5678},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd5,   32'h11FF5678, 32'h11FF5678},
            '{1'b1, 8'd12,  32'hCAFEF00D, 4'h8, 1'b0, 8'd0,   32'h0,        32'h0},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd12,  32'hCAA5A5A5, 32'hCAA5A5A5},
            '{1'b1, 8'd255, 32'h00000001, 4'hF, 1'b1, 8'd0,   IV,           IV},
            '{1'b0, 8'd0,   32'h0,        4'h0, 1'b1, 8'd255, 32'h00000001, 32'h00000001}
        };

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_init_done", 32'({rf_done, wf_done}), 32'd0);
        chk("reset_rd_valid", 32'({rf_valid, wf_valid}), 32'd0);
        chk("reset_rd_data_rf", rf_data, 32'd0);
        chk("reset_rd_data_wf", wf_data, 32'd0);

        // Traffic held on during the sweep must be ignored.
        wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'h0; wr_addr = 8'd0;
        rd_en = 1'b1; rd_addr = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_cycles");
        wr_en = 1'b0; rd_en = 1'b0;

        for (int i = 0; i < 17; i++) drive(tbl[i], 1'b0);

        for (int i = 0; i < 16; i++)
            drive('{we: 1'b1, wa: 8'(16 + i), wd: 32'h0BAD0000 + 32'(i * 3), be: 4'hF,
                    re: 1'b0, ra: 8'd0, exp_rf: 32'd0, exp_wf: 32'd0}, 1'b0);
        for (int i = 0; i < 16; i++)
            rd(8'(16 + i), 32'h0BAD0000 + 32'(i * 3));
        idle(4);
        chk("drain_rf", 32'(q_rf.size()), 32'd0);
        chk("drain_wf", 32'(q_wf.size()), 32'd0);

        // Reset in the middle of a read burst.
        for (int i = 0; i < 5; i++) rd(8'(16 + i), 32'h0BAD0000 + 32'(i * 3));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("midread_valid", 32'({rf_valid, wf_valid}), 32'd0);
        chk("midread_data_rf", rf_data, 32'd0);
        chk("midread_init_done", 32'({rf_done, wf_done}), 32'd0);
        q_rf.delete();
        q_wf.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again once the sweep has reached address 100.
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midsweep_init_done", 32'({rf_done, wf_done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit_cycles");
        rd(8'd5, IV);
        rd(8'd16, IV);
        idle(3);

`ifdef RAM_SDP_BE_PARITY_EN
        u_rf.mem[3][32] = ~u_rf.mem[3][32];
        drive('{we: 1'b0, wa: 8'd0, wd: 32'd0, be: 4'd0, re: 1'b1, ra: 8'd3, exp_rf: IV, exp_wf: IV}, 1'b1);
        rd(8'd4, IV);
        idle(3);
`endif

        chk("final_drain_rf", 32'(q_rf.size()), 32'd0);
        chk("final_drain_wf", 32'(q_wf.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
